imm_encoder: RTL
================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 8, giving the error counter width.
REQ-002 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET_N  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port IN_VALID  input  1  request valid.
REQ-005 SHALL have port IN_READY  output  1  request accepted when IN_VALID && IN_READY.
REQ-006 SHALL have port IMM_SEL  input  4  immediate type; [2:0] = U 000, J 001, I 010, B 011, S 100, SHAMT 101; [3] = unsigned variant of J/I/S.
REQ-007 SHALL have port IMM_VAL  input  32  immediate value to encode, in the decoder's IMM_EXT form.
REQ-008 SHALL have port BASE_INST  input  32  instruction whose non-immediate bits pass through unchanged.
REQ-009 SHALL have port OUT_VALID  output  1  result valid.
REQ-010 SHALL have port OUT_READY  input  1  result consumed when OUT_VALID && OUT_READY.
REQ-011 SHALL have port OUT_INST  output  32  encoded instruction.
REQ-012 SHALL have port OUT_ERR  output  1  IMM_VAL not representable for IMM_SEL.
REQ-013 SHALL have port CLR_ERR  input  1  synchronous clear of ERR_CNT.
REQ-014 SHALL have port ERR_CNT  output  ERR_CNT_W  saturating count of errored results delivered.

Function
REQ-015 SHALL be a 2-stage pipeline: stage 1 registers range check and field selection, stage 2 registers the merged word; latency = 2 cycles from acceptance to OUT_VALID with no stalls.
REQ-016 SHALL advance stage 2 when !V2 || OUT_READY, and stage 1 into stage 2 when stage 2 advances; IN_READY = !V1 || stage-1-advance (combinational path from OUT_READY permitted).
REQ-017 SHALL hold OUT_INST, OUT_ERR and OUT_VALID stable while OUT_VALID && !OUT_READY; no request is dropped or duplicated; full throughput is 1 per cycle.
REQ-018 SHALL overwrite only these bits of BASE_INST: U -> [31:12]=IMM_VAL[31:12]; J signed -> [31]=V[20], [30:21]=V[10:1], [20]=V[11], [19:12]=V[19:12]; J unsigned -> [31:12]=V[20:1]; I -> [31:20]=V[11:0]; B -> [31]=V[12], [7]=V[11], [30:25]=V[10:5], [11:8]=V[4:1]; S -> [31:25]=V[11:5], [11:7]=V[4:0]; SHAMT -> [24:20]=V[4:0].
REQ-019 SHALL flag error when: U and V[11:0]!=0; J signed and (V[0] or V[31:20] not all equal); J unsigned and (V[0] or V[31:21]!=0); I/S signed and V[31:11] not all equal; I/S unsigned and V[31:12]!=0; B and (V[0] or V[31:12] not all equal); SHAMT and V[31:5]!=0; IMM_SEL[2:0] in {110,111}.
REQ-020 SHALL, on error, output OUT_INST = BASE_INST unmodified with OUT_ERR=1.
REQ-021 SHALL guarantee round-trip: for every non-error result, the team's immediate decoder applied to OUT_INST with the same IMM_SEL returns IMM_VAL exactly.
REQ-022 SHALL ignore IMM_SEL[3] for U, B and SHAMT.
REQ-023 SHALL increment ERR_CNT on each output handshake with OUT_ERR=1, saturating at all-ones; CLR_ERR takes priority over a simultaneous increment.

Reset
REQ-024 SHALL on RESET_N low asynchronously clear both stage valids, OUT_INST, OUT_ERR and ERR_CNT to 0; IN_READY reads 1 during and after reset.
REQ-025 SHALL discard in-flight requests when reset asserts mid-operation; no output handshake follows release for them.

Structure
REQ-026 SHALL take the IMM_SEL type encodings from a shared package also used by the immediate decoder; no local redefinition.
REQ-027 SHALL place the REQ-019 checks in one combinational sub-module imm_range_check (inputs IMM_SEL, IMM_VAL; output ERR).

Verification
REQ-028 SHALL cover: I signed, IMM_VAL=0xFFFFF800, BASE_INST=0x00000013 -> OUT_INST=0x80000013, OUT_ERR=0, after 2 cycles.
REQ-029 SHALL cover: B, IMM_VAL=0x00001001 (odd) -> OUT_INST=BASE_INST, OUT_ERR=1, ERR_CNT 0->1.
REQ-030 SHALL cover: J signed, IMM_VAL=0xFFF00000, BASE_INST=0x0000006F -> OUT_INST=0x8000006F, OUT_ERR=0.
REQ-031 SHALL cover: 4 back-to-back requests with OUT_READY low 3 cycles -> IN_READY drops after 2 accepted, all 4 emerge in order, unchanged.
REQ-032 SHALL cover: 300 errored results then CLR_ERR asserted with a concurrent errored handshake -> ERR_CNT saturates at 255, then reads 0.
REQ-033 SHALL cover: RESET_N asserted with both stages valid -> OUT_VALID=0 immediately; random round-trip against the decoder over all IMM_SEL values shows no mismatch.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// Immediate-type encodings and helpers shared by the immediate encoder and decoder.
package imm_encoder_pkg;

  typedef enum logic [2:0] {
    IMM_U     = 3'b000,
    IMM_J     = 3'b001,
    IMM_I     = 3'b010,
    IMM_B     = 3'b011,
    IMM_S     = 3'b100,
    IMM_SHAMT = 3'b101
  } imm_type_e;

  localparam logic [31:0] J_SEXT_BITS  = 32'hFFF0_0000;
  localparam logic [31:0] IS_SEXT_BITS = 32'hFFFF_F800;
  localparam logic [31:0] B_SEXT_BITS  = 32'hFFFF_F000;

  typedef struct packed {
    logic        err;
    logic [31:0] base;
    logic [31:0] field;
    logic [31:0] mask;
  } stage1_t;

  // True when the bits selected by care are neither all zeros nor all ones,
  // i.e. the value is not a sign extension of the field below them.
  function automatic logic not_sext(input logic [31:0] val, input logic [31:0] care);
    return ((val & care) != care) && ((val & care) != '0);
  endfunction

endpackage

// File: rtl/imm_encoder_range_check.sv
// Combinational representability check of an IMM_EXT value for a given immediate type.
module imm_range_check
  import imm_encoder_pkg::*;
(
  input  logic [3:0]  IMM_SEL,
  input  logic [31:0] IMM_VAL,
  output logic        ERR
);

  logic uns;
  assign uns = IMM_SEL[3];

  always_comb begin
    ERR = 1'b0;
    case (imm_type_e'(IMM_SEL[2:0]))
      IMM_U:        ERR = |IMM_VAL[11:0];
      IMM_J:        ERR = IMM_VAL[0] |
                          (uns ? |IMM_VAL[31:21] : not_sext(IMM_VAL, J_SEXT_BITS));
      IMM_I, IMM_S: ERR = uns ? |IMM_VAL[31:12] : not_sext(IMM_VAL, IS_SEXT_BITS);
      IMM_B:        ERR = IMM_VAL[0] | not_sext(IMM_VAL, B_SEXT_BITS);
      IMM_SHAMT:    ERR = |IMM_VAL[31:5];
      default:      ERR = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: stage 1 checks range and scatters the immediate
// into instruction fields, stage 2 merges those fields into BASE_INST.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [3:0]           IMM_SEL,
  input  logic [31:0]          IMM_VAL,
  input  logic [31:0]          BASE_INST,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [31:0]          OUT_INST,
  output logic                 OUT_ERR,
  input  logic                 CLR_ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  logic        range_err;
  logic        v1;
  logic        v2;
  logic        adv2;
  logic        accept;
  stage1_t     s1_d;
  stage1_t     s1_q;
  logic [31:0] merged;

  imm_range_check u_range_check (
    .IMM_SEL (IMM_SEL),
    .IMM_VAL (IMM_VAL),
    .ERR     (range_err)
  );

  assign adv2      = !v2 || OUT_READY;
  assign IN_READY  = !v1 || adv2;
  assign accept    = IN_VALID && IN_READY;
  assign OUT_VALID = v2;

  always_comb begin
    s1_d.err   = range_err;
    s1_d.base  = BASE_INST;
    s1_d.field = '0;
    s1_d.mask  = '0;
    case (imm_type_e'(IMM_SEL[2:0]))
      IMM_U: begin
        s1_d.field = {IMM_VAL[31:12], 12'h000};
        s1_d.mask  = 32'hFFFF_F000;
      end
      IMM_J: begin
        s1_d.field = IMM_SEL[3] ? {IMM_VAL[20:1], 12'h000}
                                : {IMM_VAL[20], IMM_VAL[10:1], IMM_VAL[11], IMM_VAL[19:12], 12'h000};
        s1_d.mask  = 32'hFFFF_F000;
      end
      IMM_I: begin
        s1_d.field = {IMM_VAL[11:0], 20'h00000};
        s1_d.mask  = 32'hFFF0_0000;
      end
      IMM_B: begin
        s1_d.field = {IMM_VAL[12], IMM_VAL[10:5], 13'h0000, IMM_VAL[4:1], IMM_VAL[11], 7'h00};
        s1_d.mask  = 32'hFE00_0F80;
      end
      IMM_S: begin
        s1_d.field = {IMM_VAL[11:5], 13'h0000, IMM_VAL[4:0], 7'h00};
        s1_d.mask  = 32'hFE00_0F80;
      end
      IMM_SHAMT: begin
        s1_d.field = {7'h00, IMM_VAL[4:0], 20'h00000};
        s1_d.mask  = 32'h01F0_0000;
      end
      default: begin
        s1_d.field = '0;
        s1_d.mask  = '0;
      end
    endcase
  end

  // Field bits outside the mask are already zero, so OR-ing them in is enough.
  assign merged = s1_q.err ? s1_q.base : ((s1_q.base & ~s1_q.mask) | s1_q.field);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      s1_q     <= '0;
      OUT_INST <= '0;
      OUT_ERR  <= 1'b0;
    end else begin
      if (IN_READY) v1 <= IN_VALID;
      if (accept) s1_q <= s1_d;
      if (adv2) v2 <= v1;
      if (adv2 && v1) begin
        OUT_INST <= merged;
        OUT_ERR  <= s1_q.err;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ERR_CNT <= '0;
    end else if (CLR_ERR) begin
      ERR_CNT <= '0;
    end else if (v2 && OUT_READY && OUT_ERR && !(&ERR_CNT)) begin
      ERR_CNT <= ERR_CNT + ERR_CNT_W'(1);
    end
  end

endmodule
